cfi_shadow_stack: RTL and testbench
===================================

CFI_SHADOW_STACK -- requirements
Module: cfi_shadow_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of stack entries; it must be a power of two and at least 2.
REQ-002 SHALL have parameter XLEN, default 64, meaning the width of each return-address entry.
REQ-003 SHALL have parameter WRAP_ON_OVERFLOW, default 0; 1 means a push when full overwrites the oldest entry.
REQ-004 SHALL have parameter LOCK_ON_FAULT, default 1; 1 means any fault locks the stack until flush.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1 bit: clears the stack and unlocks it.
REQ-008 SHALL have port valid_i, input, 1 bit: request valid.
REQ-009 SHALL have port ready_o, output, 1 bit: request accepted when valid_i and ready_o are both high.
REQ-010 SHALL have port op_i, input, cfi_ss_op_t: NOP, PUSH, POP, POPCHK, SWAP or READCNT.
REQ-011 SHALL have port data_i, input, XLEN bits: push value, check value or swap value.
REQ-012 SHALL have port resp_valid_o, input side resp_ready_i, each 1 bit: response handshake.
REQ-013 SHALL have port resp_data_o, output, XLEN bits: popped, old-top or count value.
REQ-014 SHALL have port exc_o, output, cfi_ss_exc_t: NONE, OVERFLOW, UNDERFLOW, MISMATCH or LOCKED; valid with resp_valid_o.
REQ-015 SHALL have port count_o, output, $clog2(DEPTH+1) bits; plus empty_o and full_o, each 1 bit.

Function
REQ-016 SHALL register the response one cycle after acceptance, holding resp_valid_o, resp_data_o and exc_o stable until resp_ready_i is high.
REQ-017 SHALL drive ready_o = !flush_i && (!resp_valid_o || resp_ready_i), which gives back-to-back throughput of 1 op per cycle.
REQ-018 SHALL implement an FSM with states RUN and LOCKED: RUN->LOCKED when a faulting response is produced and LOCK_ON_FAULT=1; LOCKED->RUN only on flush_i.
REQ-019 PUSH SHALL write data_i at the top and increment count; response data is 0.
REQ-020 PUSH when full with WRAP_ON_OVERFLOW=0 SHALL report exc OVERFLOW with no state change; with WRAP_ON_OVERFLOW=1 it SHALL overwrite the oldest entry, keep count=DEPTH and report exc NONE.
REQ-021 POP SHALL return the top entry and decrement count.
REQ-022 POPCHK SHALL pop as POP and report exc MISMATCH if the popped value != data_i; the count still decrements.
REQ-023 SWAP SHALL return the top entry and replace it with data_i; count is unchanged.
REQ-024 READCNT SHALL return count zero-extended to XLEN; it never faults.
REQ-025 POP, POPCHK or SWAP when empty SHALL report exc UNDERFLOW with resp_data_o=0 and no state change.
REQ-026 NOP SHALL produce a response with exc NONE and data 0.
REQ-027 In LOCKED, every op except READCNT SHALL respond exc LOCKED and leave the stack unmodified.
REQ-028 Pointers SHALL wrap modulo DEPTH; count SHALL saturate within 0..DEPTH.
REQ-029 flush_i SHALL take priority: in the same cycle it sets count=0, state=RUN and resp_valid_o=0, and no request is accepted in that cycle.
REQ-030 empty_o SHALL equal (count==0) and full_o SHALL equal (count==DEPTH), both combinational from registered count.

Reset
REQ-031 Asserting rst_ni low SHALL asynchronously set count=0, pointers=0, state=RUN, resp_valid_o=0, resp_data_o=0 and exc_o=NONE, aborting any pending response.
REQ-032 Entry storage SHALL NOT require reset; reads of invalid entries are never observable.

Structure
REQ-033 cfi_ss_op_t and cfi_ss_exc_t SHALL live in the shared cfi_pkg alongside the CFI opcode encodings.
REQ-034 There SHALL be no sub-module: storage, pointer and FSM are inline.

Verification
REQ-035 Bench: push 0x1000, 0x2000, then POPCHK 0x2000 -> data 0x2000, exc NONE, count 1; then POPCHK 0x9999 -> data 0x1000, exc MISMATCH, state LOCKED.
REQ-036 Bench, DEPTH=4, WRAP=0: 5 pushes -> 5th gives OVERFLOW, count 4; WRAP=1: 5 pushes of 1..5 then 4 pops -> 5, 4, 3, 2, and a 5th pop gives UNDERFLOW.
REQ-037 Bench: POP on empty -> exc UNDERFLOW, data 0; with LOCK_ON_FAULT=1 a subsequent PUSH gives LOCKED and READCNT returns 0.
REQ-038 Bench: hold resp_ready_i low 3 cycles after PUSH -> ready_o low and response stable; releasing it accepts the next op in the same cycle.
REQ-039 Bench: flush_i coincident with a valid POP while locked and count 3 -> request not accepted, next cycle count 0, state RUN.
REQ-040 Bench: rst_ni asserted while resp_valid_o is pending -> outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/cfi_pkg.sv
// Shared CFI types: shadow-stack opcodes, exception codes and FSM states.
package cfi_pkg;

    localparam int unsigned CFI_SS_OP_W  = 3;
    localparam int unsigned CFI_SS_EXC_W = 3;

    typedef enum logic [CFI_SS_OP_W-1:0] {
        CFI_SS_OP_NOP     = 3'd0,
        CFI_SS_OP_PUSH    = 3'd1,
        CFI_SS_OP_POP     = 3'd2,
        CFI_SS_OP_POPCHK  = 3'd3,
        CFI_SS_OP_SWAP    = 3'd4,
        CFI_SS_OP_READCNT = 3'd5
    } cfi_ss_op_t;

    typedef enum logic [CFI_SS_EXC_W-1:0] {
        CFI_SS_EXC_NONE      = 3'd0,
        CFI_SS_EXC_OVERFLOW  = 3'd1,
        CFI_SS_EXC_UNDERFLOW = 3'd2,
        CFI_SS_EXC_MISMATCH  = 3'd3,
        CFI_SS_EXC_LOCKED    = 3'd4
    } cfi_ss_exc_t;

    typedef enum logic {
        CFI_SS_RUN    = 1'b0,
        CFI_SS_LOCKED = 1'b1
    } cfi_ss_state_t;

endpackage

// File: rtl/cfi_shadow_stack.sv
// Return-address shadow stack with checked pop, swap and fault locking.
// sp_q always points at the next free slot; the top lives at sp_q-1.
module cfi_shadow_stack
    import cfi_pkg::*;
#(
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned XLEN             = 64,
    parameter bit          WRAP_ON_OVERFLOW = 1'b0,
    parameter bit          LOCK_ON_FAULT    = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  cfi_ss_op_t                 op_i,
    input  logic [XLEN-1:0]            data_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [XLEN-1:0]            resp_data_o,
    output cfi_ss_exc_t                exc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] mem [DEPTH];

    logic [PW-1:0]   sp_q;
    logic [PW-1:0]   sp_d;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [XLEN-1:0] top;

    cfi_ss_state_t state_q;
    cfi_ss_state_t state_d;

    logic            accept;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [XLEN-1:0] rsp_data;
    cfi_ss_exc_t     rsp_exc;

    assign ready_o = !flush_i && (!resp_valid_o || resp_ready_i);
    assign accept  = valid_i && ready_o;

    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));

    assign top_idx = sp_q - PW'(1);
    assign top     = mem[top_idx];

    always_comb begin
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = sp_q;
        rsp_data = '0;
        rsp_exc  = CFI_SS_EXC_NONE;
        if (state_q == CFI_SS_LOCKED && op_i != CFI_SS_OP_READCNT) begin
            rsp_exc = CFI_SS_EXC_LOCKED;
        end else begin
            unique case (op_i)
                CFI_SS_OP_PUSH: begin
                    if (full_o && !WRAP_ON_OVERFLOW) begin
                        rsp_exc = CFI_SS_EXC_OVERFLOW;
                    end else begin
                        // When full, sp_q already sits on the oldest entry.
                        wr_en = 1'b1;
                        sp_d  = sp_q + PW'(1);
                        if (!full_o) cnt_d = cnt_q + CW'(1);
                    end
                end
                CFI_SS_OP_POP,
                CFI_SS_OP_POPCHK: begin
                    if (empty_o) begin
                        rsp_exc = CFI_SS_EXC_UNDERFLOW;
                    end else begin
                        rsp_data = top;
                        sp_d     = top_idx;
                        cnt_d    = cnt_q - CW'(1);
                        if (op_i == CFI_SS_OP_POPCHK && top != data_i)
                            rsp_exc = CFI_SS_EXC_MISMATCH;
                    end
                end
                CFI_SS_OP_SWAP: begin
                    if (empty_o) begin
                        rsp_exc = CFI_SS_EXC_UNDERFLOW;
                    end else begin
                        rsp_data = top;
                        wr_en    = 1'b1;
                        wr_idx   = top_idx;
                    end
                end
                CFI_SS_OP_READCNT: rsp_data = XLEN'(cnt_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CFI_SS_RUN: begin
                if (accept && LOCK_ON_FAULT && rsp_exc != CFI_SS_EXC_NONE)
                    state_d = CFI_SS_LOCKED;
            end
            CFI_SS_LOCKED: ;
        endcase
        if (flush_i) state_d = CFI_SS_RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= CFI_SS_RUN;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q         <= '0;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            exc_o        <= CFI_SS_EXC_NONE;
        end else if (flush_i) begin
            sp_q         <= '0;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
        end else if (accept) begin
            sp_q         <= sp_d;
            cnt_q        <= cnt_d;
            resp_valid_o <= 1'b1;
            resp_data_o  <= rsp_data;
            exc_o        <= rsp_exc;
        end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && wr_en) mem[wr_idx] <= data_i;
    end

endmodule

// File: tb/tb_cfi_shadow_stack.sv
// Bench for cfi_shadow_stack: three configurations driven in lockstep,
// checked every cycle against a queue-based model plus literal expectations.
module tb_cfi_shadow_stack;
    import cfi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        resp_ready = 1'b1;
    cfi_ss_op_t  op = CFI_SS_OP_NOP;
    logic [63:0] din = '0;

    logic [2:0]  rdy_a;
    logic [2:0]  rv_a;
    logic [2:0]  em_a;
    logic [2:0]  fu_a;
    logic [63:0] rd_a [3];
    cfi_ss_exc_t ex_a [3];
    logic [7:0]  cnt_a [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance 0: DEPTH 16, lock. Instance 1: DEPTH 4, no wrap, lock.
    // Instance 2: DEPTH 4, wrap, no lock.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 16 : 4;
        logic [$clog2(D+1)-1:0] cnt;
        cfi_shadow_stack #(
            .DEPTH(D),
            .XLEN(64),
            .WRAP_ON_OVERFLOW(g == 2),
            .LOCK_ON_FAULT(g != 2)
        ) u_dut (
            .clk_i(clk),
            .rst_ni(rst_n),
            .flush_i(flush),
            .valid_i(valid),
            .ready_o(rdy_a[g]),
            .op_i(op),
            .data_i(din),
            .resp_valid_o(rv_a[g]),
            .resp_ready_i(resp_ready),
            .resp_data_o(rd_a[g]),
            .exc_o(ex_a[g]),
            .count_o(cnt),
            .empty_o(em_a[g]),
            .full_o(fu_a[g])
        );
        assign cnt_a[g] = 8'(cnt);
    end

    function automatic int dep_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic bit wrap_of(input int i);
        return i == 2;
    endfunction

    function automatic bit lock_of(input int i);
        return i != 2;
    endfunction

    task automatic chk(input string n, input int i,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", n, i, act, exp);
        end
    endtask

    logic [63:0] mq [3][$];
    bit          m_rv [3];
    bit          m_lk [3];
    logic [63:0] m_rd [3];
    cfi_ss_exc_t m_ex [3];

    task automatic model_op(input int i);
        cfi_ss_exc_t e;
        logic [63:0] r;
        e = CFI_SS_EXC_NONE;
        r = '0;
        if (m_lk[i] && op != CFI_SS_OP_READCNT) begin
            e = CFI_SS_EXC_LOCKED;
        end else begin
            case (op)
                CFI_SS_OP_PUSH: begin
                    if (mq[i].size() == dep_of(i)) begin
                        if (wrap_of(i)) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(din);
                        end else begin
                            e = CFI_SS_EXC_OVERFLOW;
                        end
                    end else begin
                        mq[i].push_back(din);
                    end
                end
                CFI_SS_OP_POP, CFI_SS_OP_POPCHK: begin
                    if (mq[i].size() == 0) begin
                        e = CFI_SS_EXC_UNDERFLOW;
                    end else begin
                        r = mq[i].pop_back();
                        if (op == CFI_SS_OP_POPCHK && r != din)
                            e = CFI_SS_EXC_MISMATCH;
                    end
                end
                CFI_SS_OP_SWAP: begin
                    if (mq[i].size() == 0) begin
                        e = CFI_SS_EXC_UNDERFLOW;
                    end else begin
                        r = mq[i][mq[i].size()-1];
                        mq[i][mq[i].size()-1] = din;
                    end
                end
                CFI_SS_OP_READCNT: r = 64'(mq[i].size());
                default: ;
            endcase
        end
        if (e != CFI_SS_EXC_NONE && lock_of(i)) m_lk[i] = 1'b1;
        m_rd[i] = r;
        m_ex[i] = e;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mq[i].delete();
                m_lk[i] = 1'b0;
                m_rv[i] = 1'b0;
                m_rd[i] = '0;
                m_ex[i] = CFI_SS_EXC_NONE;
            end else if (flush) begin
                mq[i].delete();
                m_lk[i] = 1'b0;
                m_rv[i] = 1'b0;
            end else if (valid && (!m_rv[i] || resp_ready)) begin
                model_op(i);
                m_rv[i] = 1'b1;
            end else if (resp_ready) begin
                m_rv[i] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("ready", i, 64'(rdy_a[i]),
                64'(!flush && (!m_rv[i] || resp_ready)));
            chk("resp_valid", i, 64'(rv_a[i]), 64'(m_rv[i]));
            chk("count", i, 64'(cnt_a[i]), 64'(mq[i].size()));
            chk("empty", i, 64'(em_a[i]), 64'(mq[i].size() == 0));
            chk("full", i, 64'(fu_a[i]), 64'(mq[i].size() == dep_of(i)));
            if (m_rv[i]) begin
                chk("resp_data", i, rd_a[i], m_rd[i]);
                chk("exc", i, 64'(ex_a[i]), 64'(m_ex[i]));
            end
        end
    end

    task automatic issue(input cfi_ss_op_t o, input logic [63:0] d);
        valid = 1'b1;
        op    = o;
        din   = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = CFI_SS_OP_NOP;
        din   = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 0, 64'(cnt_a[0]), 64'd0);
        chk("rst_empty", 0, 64'(em_a[0]), 64'd1);
        chk("rst_rvalid", 0, 64'(rv_a[0]), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(CFI_SS_OP_PUSH, 64'h1000);
        issue(CFI_SS_OP_PUSH, 64'h2000);
        issue(CFI_SS_OP_POPCHK, 64'h2000);
        chk("popchk_data", 0, rd_a[0], 64'h2000);
        chk("popchk_exc", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_NONE));
        chk("popchk_count", 0, 64'(cnt_a[0]), 64'd1);
        issue(CFI_SS_OP_POPCHK, 64'h9999);
        chk("mismatch_data", 0, rd_a[0], 64'h1000);
        chk("mismatch_exc", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_MISMATCH));
        issue(CFI_SS_OP_PUSH, 64'h5);
        chk("locked_push", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_LOCKED));
        do_flush();

        issue(CFI_SS_OP_POP, 64'h0);
        chk("uflow_exc", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_UNDERFLOW));
        chk("uflow_data", 0, rd_a[0], 64'h0);
        issue(CFI_SS_OP_PUSH, 64'h77);
        chk("uflow_lock", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_LOCKED));
        issue(CFI_SS_OP_READCNT, 64'h0);
        chk("readcnt_locked", 0, rd_a[0], 64'd0);
        chk("readcnt_exc", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_NONE));
        do_flush();

        for (int k = 1; k <= 4; k++) issue(CFI_SS_OP_PUSH, 64'(k));
        issue(CFI_SS_OP_PUSH, 64'd5);
        chk("ovf_exc", 1, 64'(ex_a[1]), 64'(CFI_SS_EXC_OVERFLOW));
        chk("ovf_count", 1, 64'(cnt_a[1]), 64'd4);
        chk("wrap_exc", 2, 64'(ex_a[2]), 64'(CFI_SS_EXC_NONE));
        chk("wrap_count", 2, 64'(cnt_a[2]), 64'd4);
        for (int k = 0; k < 4; k++) begin
            issue(CFI_SS_OP_POP, 64'h0);
            chk("wrap_pop", 2, rd_a[2], 64'(5 - k));
        end
        issue(CFI_SS_OP_POP, 64'h0);
        chk("wrap_uflow", 2, 64'(ex_a[2]), 64'(CFI_SS_EXC_UNDERFLOW));
        chk("deep_pop", 0, rd_a[0], 64'd1);
        do_flush();

        issue(CFI_SS_OP_PUSH, 64'h11);
        issue(CFI_SS_OP_SWAP, 64'h22);
        chk("swap_old", 0, rd_a[0], 64'h11);
        chk("swap_count", 0, 64'(cnt_a[0]), 64'd1);
        issue(CFI_SS_OP_POP, 64'h0);
        chk("swap_new", 0, rd_a[0], 64'h22);
        issue(CFI_SS_OP_NOP, 64'hffff);
        chk("nop_data", 0, rd_a[0], 64'h0);
        chk("nop_exc", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_NONE));
        issue(CFI_SS_OP_SWAP, 64'h33);
        chk("swap_uflow", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_UNDERFLOW));
        do_flush();

        resp_ready = 1'b0;
        issue(CFI_SS_OP_PUSH, 64'hab);
        valid = 1'b1;
        op    = CFI_SS_OP_POP;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("stall_ready", 0, 64'(rdy_a[0]), 64'd0);
            chk("stall_rvalid", 0, 64'(rv_a[0]), 64'd1);
        end
        resp_ready = 1'b1;
        #1;
        chk("release_ready", 0, 64'(rdy_a[0]), 64'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = CFI_SS_OP_NOP;
        chk("release_pop", 0, rd_a[0], 64'hab);
        chk("release_count", 0, 64'(cnt_a[0]), 64'd0);

        for (int k = 0; k < 4; k++) issue(CFI_SS_OP_PUSH, 64'(k + 64'h40));
        issue(CFI_SS_OP_POPCHK, 64'h0);
        chk("lock3_count", 0, 64'(cnt_a[0]), 64'd3);
        flush = 1'b1;
        valid = 1'b1;
        op    = CFI_SS_OP_POP;
        #1;
        chk("flush_ready", 0, 64'(rdy_a[0]), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid = 1'b0;
        op    = CFI_SS_OP_NOP;
        chk("flush_count", 0, 64'(cnt_a[0]), 64'd0);
        chk("flush_rvalid", 0, 64'(rv_a[0]), 64'd0);
        issue(CFI_SS_OP_PUSH, 64'h7);
        chk("flush_run", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_NONE));
        @(posedge clk);
        #1;

        resp_ready = 1'b0;
        issue(CFI_SS_OP_PUSH, 64'h42);
        chk("pend_rvalid", 0, 64'(rv_a[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", 0, 64'(rv_a[0]), 64'd0);
        chk("arst_data", 0, rd_a[0], 64'd0);
        chk("arst_exc", 0, 64'(ex_a[0]), 64'(CFI_SS_EXC_NONE));
        chk("arst_count", 0, 64'(cnt_a[0]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
